// File: rtl/mmio_seg7_led_out_if.sv
// IO bus bundle between the CPU-side decode and the LED / 7-segment output block.
// Latency: none in the bundle itself; io_rdata is registered by the slave and valid one cycle after io_re.
// Backpressure: none; every io_we / io_re strobe is accepted in the cycle it is presented.
// Ports: io_addr (byte offset, [3:2] selects a register), io_we/io_be/io_wdata (write),
//        io_re (read strobe), io_rdata (registered read data, driven by the slave).
interface mmio_seg7_led_out_if;
  logic [3:0]  io_addr;
  logic        io_we;
  logic [3:0]  io_be;
  logic [31:0] io_wdata;
  logic        io_re;
  logic [31:0] io_rdata;

  modport master (
    output io_addr,
    output io_we,
    output io_be,
    output io_wdata,
    output io_re,
    input  io_rdata
  );

  modport slave (
    input  io_addr,
    input  io_we,
    input  io_be,
    input  io_wdata,
    input  io_re,
    output io_rdata
  );
endinterface

// File: rtl/mmio_seg7_led_out.sv
// Memory-mapped LED register plus 8-digit multiplexed active-low hex 7-segment driver.
// Latency: leds_pin updates on the write edge; seg_an/seg_cat one edge later; io_rdata one edge after io_re.
// Backpressure: none; writes and reads are single-cycle strobes that are always accepted.
// Ports: sys_clk, rst (async, active-high); io (slave side of the IO bus);
//        leds_pin[23:0] active-high; seg_an[7:0] anodes active-low (bit 0 = rightmost);
//        seg_cat[7:0] cathodes active-low ([0]=a .. [6]=g, [7]=dp).
module mmio_seg7_led_out #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  mmio_seg7_led_out_if.slave   io,
  output logic [23:0]          leds_pin,
  output logic [7:0]           seg_an,
  output logic [7:0]           seg_cat
);

  // Prescaler needs at least one bit even when every cycle is a tick.
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] REG_LED    = 2'd0;
  localparam logic [1:0] REG_VALUE  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [23:0]      led_q;
  logic [31:0]      val_q;
  logic [7:0]       mask_q;
  logic [7:0]       dp_q;
  logic             blank_q;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       idx;
  logic [31:0]      rdata_q;

  logic [1:0]       reg_sel;
  logic             tick;
  logic [31:0]      rd_mux;
  logic [3:0]       cur_nib;
  logic [7:0]       an_nxt;
  logic [7:0]       cat_nxt;

  // Byte-lane bits [1:0] of the address carry no meaning here.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^io.io_addr[1:0];

  assign reg_sel  = io.io_addr[3:2];
  assign tick     = (div_cnt == DIV_MAX);
  assign leds_pin = led_q;
  assign io.io_rdata = rdata_q;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Register file: byte-enabled writes; STATUS has no storage so writes to it fall through.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      val_q   <= '0;
      mask_q  <= 8'hFF;
      dp_q    <= '0;
      blank_q <= 1'b0;
    end else if (io.io_we) begin
      case (reg_sel)
        REG_LED: begin
          for (int b = 0; b < 3; b++) begin
            if (io.io_be[b]) led_q[8*b +: 8] <= io.io_wdata[8*b +: 8];
          end
        end
        REG_VALUE: begin
          for (int b = 0; b < 4; b++) begin
            if (io.io_be[b]) val_q[8*b +: 8] <= io.io_wdata[8*b +: 8];
          end
        end
        REG_CTRL: begin
          if (io.io_be[0]) mask_q  <= io.io_wdata[7:0];
          if (io.io_be[1]) dp_q    <= io.io_wdata[15:8];
          if (io.io_be[2]) blank_q <= io.io_wdata[16];
        end
        default: ;
      endcase
    end
  end

  // Read mux samples pre-write state, so a same-cycle read/write returns the old value.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_LED:    rd_mux = {8'h00, led_q};
      REG_VALUE:  rd_mux = val_q;
      REG_CTRL:   rd_mux = {15'h0000, blank_q, dp_q, mask_q};
      REG_STATUS: rd_mux = {29'h0, idx};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (io.io_re) begin
      rdata_q <= rd_mux;
    end
  end

  // Scan timing: writes never touch the prescaler or digit index.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Decode for the digit currently being scanned; registered below.
  always_comb begin
    cur_nib = val_q[{idx, 2'b00} +: 4];
    an_nxt  = 8'hFF;
    cat_nxt = 8'hFF;
    if (!blank_q) begin
      if (mask_q[idx]) an_nxt[idx] = 1'b0;
      cat_nxt = {~dp_q[idx], hex_glyph(cur_nib)};
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      seg_an  <= 8'hFF;
      seg_cat <= 8'hFF;
    end else begin
      seg_an  <= an_nxt;
      seg_cat <= cat_nxt;
    end
  end

endmodule

// File: doc/mmio_seg7_led_out.md
# mmio_seg7_led_out

Memory-mapped output peripheral: the CPU's write-side counterpart to the switch input port. It holds the LED pattern and an 8-digit hex value written by the CPU over the IO bus. It time-multiplexes the value onto an active-low 7-segment display. It sits in `top` beside the switch reader, on the same IO bus decode, driving board pins.

## Interface
- `CLK_DIV`, default 100000: sys_clk cycles per digit slot; legal range ≥1.
- `sys_clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `io_addr` in 4: byte offset within the block; bits [3:2] select the register, bits [1:0] are ignored.
- `io_we` in 1: write strobe, one cycle per write.
- `io_be` in 4: byte enables for a write; bit n enables `io_wdata[8n+7:8n]`.
- `io_wdata` in 32: write data.
- `io_re` in 1: read strobe.
- `io_rdata` out 32: registered read data.
- `leds_pin` out 24: LED drive, active-high.
- `seg_an` out 8: digit anodes, active-low; bit 0 is the rightmost digit.
- `seg_cat` out 8: segment cathodes, active-low; [0]=a … [6]=g, [7]=dp.

## Operation
Registers, selected by `io_addr[3:2]`:
- 0 LED: bits [23:0] drive `leds_pin`. Bits [31:24] are not stored and read 0. Reset 0.
- 1 SEG_VALUE: 8 hex nibbles; nibble k (bits [4k+3:4k]) is shown on digit k. Reset 0.
- 2 SEG_CTRL:
  - [7:0] digit enable mask, reset 8'hFF.
  - [15:8] dp mask, reset 0.
  - [16] blank, reset 0.
  - Other bits read 0.
- 3 STATUS: read-only. [2:0] is the current scan index; other bits read 0. Writes are ignored.

Writes:
- On `io_we`, only bytes with `io_be` set are updated.
- Unwritten bytes hold their value.

Reads:
- On `io_re`, `io_rdata` loads the selected register on the next edge.
- Otherwise `io_rdata` holds its last value.

Scan:
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and wraps to 0.
- `tick` is asserted while `div_cnt == CLK_DIV-1`.
- On `tick`, scan index `idx` advances mod 8 (7→0). With CLK_DIV=1, `tick` is asserted every cycle.

Display:
- Each cycle, the outputs register the decode of the current `idx` and register contents.
- `seg_an[idx]` = 0 when mask[idx]=1 and blank=0. All other anodes = 1.
- `seg_cat[6:0]` = active-low hex glyph of nibble `idx`:
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30
  - 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78
  - 8→7'h00, 9→7'h10, A→7'h08, b→7'h03
  - C→7'h46, d→7'h21, E→7'h06, F→7'h0E
- `seg_cat[7]` = ~dp_mask[idx].
- When blank=1, `seg_cat` = 8'hFF and `seg_an` = 8'hFF.

## Timing
- On `rst` assertion (asynchronous): `leds_pin`=0, `seg_an`=8'hFF, `seg_cat`=8'hFF, `io_rdata`=0, `idx`=0, `div_cnt`=0. All registers take their reset values.
- Write to pin latency: write accepted at edge N; `leds_pin` changes at N. `seg_an`/`seg_cat` reflect the new value at edge N+1.
- Read latency: 1 cycle. `io_rdata` is valid after the edge that samples `io_re`.
- Simultaneous `io_re` and `io_we` to the same register: `io_rdata` returns the pre-write value.
- `idx` change to pin change: 1 cycle.
- Each digit slot lasts exactly CLK_DIV cycles; the full frame is 8·CLK_DIV cycles.
- Writes do not disturb `div_cnt` or `idx`. A mid-frame write takes effect at the next output register update.
- `rst` mid-scan: everything returns to the reset state immediately. After release, `idx`=0 and the first `tick` comes CLK_DIV cycles later.
- `io_we` with `io_be`=0: no state change.

## Test plan
- Reset, CLK_DIV=4: hold `rst` for 2 cycles mid-operation. Required: all outputs at their reset values asynchronously. After release, `seg_an` steps FE,FD,FB,…,7F,FE with 4 cycles per step. `seg_cat`=8'hC0 (digit 0, dp off) throughout.
- Write SEG_VALUE=32'h0000_0018 with be=4'hF. Required: `seg_cat` reads 8'h80 while `seg_an`=8'hFE and 8'hF9 while `seg_an`=8'hFD. Reading reg 1 returns 32'h18 one cycle after `io_re`.
- Write LED=32'hFFFF_FFFF, then LED with be=4'b0001 and wdata=32'h0000_00A5. Required: `leds_pin`=24'hFFFFA5. Readback returns 32'h00FFFFA5.
- Write SEG_CTRL=32'h0000_0105 (mask 05, dp 01). Required: only digits 0 and 2 drive an anode low; digit 0 shows `seg_cat[7]`=0. Then set blank (bit16). Required: `seg_an`=8'hFF and `seg_cat`=8'hFF next cycle.
- Same-cycle read and write of SEG_VALUE (old 32'h1234, new 32'h5678). Required: `io_rdata`=32'h1234, and the following read returns 32'h5678. A write to STATUS is ignored, and a STATUS read returns the current `idx`.
- CLK_DIV=1: `seg_an` rotates every cycle and wraps from 8'h7F to 8'hFE.
